// File: rtl/risc_pkg.sv
// risc_pkg: shared encodings for the RISC CPU (controller, ALU, datapath).
//   OPC_W / PHASE_W   - opcode and phase field widths
//   INST_ADDR..STORE  - controller phase encodings
//   OP_HLT..OP_JMP    - instruction opcode encodings
//   ctrl_t            - bundle of controller strobes driven each cycle
package risc_pkg;

  localparam int unsigned OPC_W   = 3;
  localparam int unsigned PHASE_W = 3;

  typedef logic [OPC_W-1:0]   opc_t;
  typedef logic [PHASE_W-1:0] phase_t;

  // Phase encodings; one instruction walks all eight in order.
  localparam phase_t INST_ADDR  = 3'd0;
  localparam phase_t INST_FETCH = 3'd1;
  localparam phase_t INST_LOAD  = 3'd2;
  localparam phase_t IDLE       = 3'd3;
  localparam phase_t OP_ADDR    = 3'd4;
  localparam phase_t OP_FETCH   = 3'd5;
  localparam phase_t ALU_OP     = 3'd6;
  localparam phase_t STORE      = 3'd7;

  // Opcode encodings.
  localparam opc_t OP_HLT = 3'd0;
  localparam opc_t OP_SKZ = 3'd1;
  localparam opc_t OP_ADD = 3'd2;
  localparam opc_t OP_AND = 3'd3;
  localparam opc_t OP_XOR = 3'd4;
  localparam opc_t OP_LDA = 3'd5;
  localparam opc_t OP_STO = 3'd6;
  localparam opc_t OP_JMP = 3'd7;

  // Controller strobes; field order is the order of the output ports.
  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic inc_pc;
    logic ld_pc;
    logic data_e;
    logic halt;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF = '0;

  // Instructions that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(input opc_t op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage : risc_pkg

// File: rtl/risc_controller.sv
// risc_controller: eight-phase sequencer for the accumulator CPU.
// A free-running phase counter steps through fetch/execute; outputs are a
// pure decode of the phase register, the current opcode, zero and the
// sticky halted flag, so every strobe is valid in the cycle of its phase.
//   clk, rst_n   - system clock, async active-low reset
//   opcode       - IR opcode field (valid from IDLE onward)
//   zero         - accumulator-zero flag, consulted only in ALU_OP
//   phase        - current phase
//   sel          - address mux: 1 = PC, 0 = operand address
//   rd, wr       - memory read / write
//   ld_ir, ld_ac - load instruction register / accumulator
//   inc_pc, ld_pc- increment PC / load PC from operand
//   data_e       - drive accumulator onto the data bus
//   halt         - CPU halted
module risc_controller #(
  parameter int unsigned OPC_W = risc_pkg::OPC_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [OPC_W-1:0]              opcode,
  input  logic                          zero,
  output logic [risc_pkg::PHASE_W-1:0]  phase,
  output logic                          sel,
  output logic                          rd,
  output logic                          wr,
  output logic                          ld_ir,
  output logic                          ld_ac,
  output logic                          inc_pc,
  output logic                          ld_pc,
  output logic                          data_e,
  output logic                          halt
);

  import risc_pkg::*;

  phase_t phase_q;
  phase_t phase_d;
  logic   halted_q;
  logic   halted_d;
  ctrl_t  ctrl_c;
  opc_t   op;
  logic   aluop;

  assign op    = opc_t'(opcode);
  assign aluop = is_aluop(op);

  // Phase register and sticky halted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next phase and output decode.
  always_comb begin
    phase_d  = phase_q + PHASE_W'(1);
    halted_d = halted_q;
    ctrl_c   = CTRL_OFF;

    if (halted_q) begin
      // Frozen at OP_ADDR; only reset gets out of here.
      phase_d     = phase_q;
      ctrl_c.halt = 1'b1;
    end else begin
      // HLT is recognised while in OP_ADDR; the sequencer stays put from then on.
      if ((phase_q == OP_ADDR) && (op == OP_HLT)) begin
        halted_d = 1'b1;
        phase_d  = OP_ADDR;
      end

      case (phase_q)
        INST_ADDR: begin
          ctrl_c.sel = 1'b1;
        end
        INST_FETCH: begin
          ctrl_c.sel = 1'b1;
          ctrl_c.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          ctrl_c.sel   = 1'b1;
          ctrl_c.rd    = 1'b1;
          ctrl_c.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          ctrl_c.inc_pc = (op != OP_HLT);
          ctrl_c.halt   = (op == OP_HLT);
        end
        OP_FETCH: begin
          ctrl_c.rd = aluop;
        end
        ALU_OP: begin
          ctrl_c.rd     = aluop;
          ctrl_c.inc_pc = (op == OP_SKZ) && zero;
          ctrl_c.ld_pc  = (op == OP_JMP);
          ctrl_c.data_e = (op == OP_STO);
        end
        STORE: begin
          ctrl_c.rd     = aluop;
          ctrl_c.ld_ac  = aluop;
          ctrl_c.ld_pc  = (op == OP_JMP);
          ctrl_c.wr     = (op == OP_STO);
          ctrl_c.data_e = (op == OP_STO);
        end
        default: begin
        end
      endcase
    end
  end

  assign phase  = phase_q;
  assign sel    = ctrl_c.sel;
  assign rd     = ctrl_c.rd;
  assign wr     = ctrl_c.wr;
  assign ld_ir  = ctrl_c.ld_ir;
  assign ld_ac  = ctrl_c.ld_ac;
  assign inc_pc = ctrl_c.inc_pc;
  assign ld_pc  = ctrl_c.ld_pc;
  assign data_e = ctrl_c.data_e;
  assign halt   = ctrl_c.halt;

`ifndef SYNTHESIS
  // Bus-safety invariants: never write while reading, never write and jump together.
  a_wr_ld_pc: assert property (@(posedge clk) disable iff (!rst_n) !(wr && ld_pc));
  a_wr_rd:    assert property (@(posedge clk) disable iff (!rst_n) !(wr && rd));
  a_halt_hold: assert property (@(posedge clk) disable iff (!rst_n)
                                halted_q |=> (phase_q == OP_ADDR));
`endif

endmodule : risc_controller

// File: tb/tb_risc_controller.sv
// tb_risc_controller: directed per-phase checks of the controller decode,
// halt behaviour and asynchronous reset, against hand-built phase masks.
module tb_risc_controller;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  // {sel,rd,wr,ld_ir,ld_ac,inc_pc,ld_pc,data_e,halt}
  localparam logic [8:0] VEC_RESET = 9'b1_0000_0000;
  localparam logic [8:0] VEC_HALT  = 9'b0_0000_0001;

  risc_controller #(.OPC_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .zero   (zero),
    .phase  (phase),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .halt   (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] out_vec();
    return {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hold reset across a negedge, check reset outputs, release away from posedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_phase", 16'(phase), 16'd0);
    check("rst_vec", 16'(out_vec()), 16'(VEC_RESET));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_phase", 16'(phase), 16'd0);
    check("rel_vec", 16'(out_vec()), 16'(VEC_RESET));
  endtask

  // One full instruction; bit p of each mask is the expected strobe in phase p.
  task automatic run_instr(input string name, input logic [2:0] op, input logic [7:0] zmask,
                           input logic [7:0] m_sel, input logic [7:0] m_rd,
                           input logic [7:0] m_wr, input logic [7:0] m_ldir,
                           input logic [7:0] m_ldac, input logic [7:0] m_inc,
                           input logic [7:0] m_ldpc, input logic [7:0] m_de);
    logic [8:0] exp;
    opcode = op;
    zero   = zmask[0];
    do_reset();
    for (int p = 0; p < 8; p++) begin
      zero = zmask[p];
      #1;
      exp = {m_sel[p], m_rd[p], m_wr[p], m_ldir[p], m_ldac[p], m_inc[p], m_ldpc[p], m_de[p], 1'b0};
      check($sformatf("%s p%0d phase", name, p), 16'(phase), 16'(p));
      check($sformatf("%s p%0d vec", name, p), 16'(out_vec()), 16'(exp));
      check($sformatf("%s p%0d wr_conflict", name, p), 16'({wr & ld_pc, wr & rd}), 16'd0);
      @(negedge clk);
    end
    #1;
    check($sformatf("%s wrap", name), 16'(phase), 16'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = ADD;
    zero   = 1'b0;
    @(negedge clk);

    //          name        op    zero   sel    rd     wr     ld_ir  ld_ac  inc_pc ld_pc  data_e
    run_instr("ADD",      ADD,  8'h00, 8'h0F, 8'hEE, 8'h00, 8'h0C, 8'h80, 8'h10, 8'h00, 8'h00);
    run_instr("AND",      AND_, 8'hFF, 8'h0F, 8'hEE, 8'h00, 8'h0C, 8'h80, 8'h10, 8'h00, 8'h00);
    run_instr("XOR",      XOR_, 8'h00, 8'h0F, 8'hEE, 8'h00, 8'h0C, 8'h80, 8'h10, 8'h00, 8'h00);
    run_instr("LDA",      LDA,  8'h00, 8'h0F, 8'hEE, 8'h00, 8'h0C, 8'h80, 8'h10, 8'h00, 8'h00);
    run_instr("STO",      STO,  8'h00, 8'h0F, 8'h0E, 8'h80, 8'h0C, 8'h00, 8'h10, 8'h00, 8'hC0);
    run_instr("SKZ_z1",   SKZ,  8'hFF, 8'h0F, 8'h0E, 8'h00, 8'h0C, 8'h00, 8'h50, 8'h00, 8'h00);
    run_instr("SKZ_z0",   SKZ,  8'h00, 8'h0F, 8'h0E, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00);
    // zero high everywhere except ALU_OP: must not skip
    run_instr("SKZ_zoth", SKZ,  8'hBF, 8'h0F, 8'h0E, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00);
    run_instr("JMP",      JMP,  8'hFF, 8'h0F, 8'h0E, 8'h00, 8'h0C, 8'h00, 8'h10, 8'hC0, 8'h00);

    // HLT: normal fetch, then frozen at OP_ADDR with only halt asserted.
    opcode = HLT;
    zero   = 1'b0;
    do_reset();
    for (int p = 0; p < 4; p++) @(negedge clk);
    #1;
    check("HLT p4 phase", 16'(phase), 16'd4);
    check("HLT p4 vec", 16'(out_vec()), 16'(VEC_HALT));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      // Opcode/zero churn after halting must not matter.
      opcode = 3'(i);
      zero   = i[0];
      #1;
      check($sformatf("HLT hold%0d phase", i), 16'(phase), 16'd4);
      check($sformatf("HLT hold%0d vec", i), 16'(out_vec()), 16'(VEC_HALT));
    end
    opcode = ADD;
    do_reset();
    @(negedge clk);
    #1;
    check("HLT after_rst phase", 16'(phase), 16'd1);
    check("HLT after_rst halt", 16'(halt), 16'd0);

    // Asynchronous reset in ALU_OP of a store: no wr pulse, instruction abandoned.
    opcode = STO;
    do_reset();
    for (int p = 0; p < 6; p++) @(negedge clk);
    #1;
    check("ARST p6 phase", 16'(phase), 16'd6);
    check("ARST p6 data_e", 16'(data_e), 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ARST async phase", 16'(phase), 16'd0);
    check("ARST async vec", 16'(out_vec()), 16'(VEC_RESET));
    @(posedge clk);
    #1;
    check("ARST held phase", 16'(phase), 16'd0);
    check("ARST held wr", 16'(wr), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ARST rel vec", 16'(out_vec()), 16'(VEC_RESET));
    @(negedge clk);
    #1;
    check("ARST first_edge phase", 16'(phase), 16'd1);
    check("ARST first_edge wr", 16'(wr), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_risc_controller
